muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_core.sv | 86 ++++++++
 rtl/muldiv_sequencer.sv | 102 ++++++++++
 tb/tb_muldiv_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the MULT/DIV sequencer and its iteration datapath.
// Holds the FSM state encoding, op encodings, iteration count and a magnitude helper.
// Signedness is selected by the MULDIV_SIGNED_EN macro in muldiv_core.
package muldiv_pkg;

  // Sequencer states; explicit 3-bit codes keep the encoding stable for legacy tools.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    RUN   = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Number of shift-add / shift-subtract iterations per operation.
  localparam int ITER = 32;

  // Absolute value of a 32-bit operand when treated as signed; pass-through otherwise.
  // The most negative value maps to 0x80000000, which is its correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iteration datapath: 64-bit shift-add multiplier, restoring divider, sign fix-up.
// Latency: load 1 cycle, 32 step cycles, 1 fix cycle; results held until next fix.
// No backpressure: advances only on the load/step/fix strobes from the sequencer.
// Macro MULDIV_SIGNED_EN: two's-complement operands with sign correction; else unsigned.
module muldiv_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        fix,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

`ifdef MULDIV_SIGNED_EN
  localparam logic SGN = 1'b1;
`else
  localparam logic SGN = 1'b0;
`endif

  logic [63:0] prod;     // MULT: {partial sum, remaining multiplier bits}
  logic [31:0] rem;      // DIV: partial remainder, always < divisor between steps
  logic [31:0] quo;      // DIV: dividend bits shifting out, quotient bits shifting in
  logic [31:0] opnd;     // multiplicand magnitude (MULT) or divisor magnitude (DIV)
  logic        neg_q;    // product / quotient must be negated
  logic        neg_r;    // remainder takes the dividend's (negative) sign

  logic [32:0] sum33;
  logic [63:0] prod_nxt;
  logic [32:0] part;     // 33-bit partial remainder after the shift
  logic [32:0] diff;

  // One iteration of each algorithm, computed combinationally from current state.
  always_comb begin
    sum33    = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opnd} : 33'd0);
    prod_nxt = {sum33, prod[31:1]};
    part     = {rem, quo[31]};
    diff     = part - {1'b0, opnd};
  end

  // Operand load, iteration and sign fix-up registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod   <= 64'd0;
      rem    <= 32'd0;
      quo    <= 32'd0;
      opnd   <= 32'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
    end else if (load) begin
      prod  <= {32'd0, mag32(b, SGN)};
      quo   <= mag32(a, SGN);
      rem   <= 32'd0;
      opnd  <= (op == OP_MULT) ? mag32(a, SGN) : mag32(b, SGN);
      neg_q <= SGN & (a[31] ^ b[31]);
      neg_r <= SGN & a[31];
    end else if (step) begin
      if (op == OP_MULT) begin
        prod <= prod_nxt;
      end else if (!diff[32]) begin
        // Trial subtraction did not borrow: keep it, quotient bit is 1.
        rem <= diff[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        // Restore: keep the shifted remainder, quotient bit is 0.
        rem <= part[31:0];
        quo <= {quo[30:0], 1'b0};
      end
    end else if (fix) begin
      if (op == OP_MULT) begin
        {res_hi, res_lo} <= neg_q ? (~prod + 64'd1) : prod;
      end else begin
        res_lo <= neg_q ? (~quo + 32'd1) : quo;
        res_hi <= neg_r ? (~rem + 32'd1) : rem;
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// MULT/DIV sequencer: latches operands on start, runs muldiv_core, publishes HI/LO.
// Latency: start at edge N -> done high after edge N+35; div-by-zero -> div0 after edge N+1.
// No backpressure: start is ignored while busy or during the done cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] LAST_ITER = 6'(ITER - 1);

  state_e      state;
  logic [5:0]  cnt;
  logic        op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] core_hi;
  logic [31:0] core_lo;

  // Sequencing FSM, iteration counter, operand latch and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 6'd0;
      op_q  <= OP_MULT;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      done  <= 1'b0;
      div0  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (start && !done) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (op_q == OP_DIV && b_q == 32'd0) begin
            div0  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt   <= 6'd0;
            state <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 6'd1;
          if (cnt == LAST_ITER) state <= FIX;
        end
        FIX: state <= DONE;
        DONE: begin
          done  <= 1'b1;
          hi    <= core_hi;
          lo    <= core_lo;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write enables track the result pulse; busy covers every non-idle state.
  always_comb begin
    hi_we = done;
    lo_we = done;
    busy  = (state != IDLE);
  end

  muldiv_core u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (state == CHECK),
    .step   (state == RUN),
    .fix    (state == FIX),
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .res_hi (core_hi),
    .res_lo (core_lo)
  );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus random ops
// checked against an arithmetic reference model (signed when MULDIV_SIGNED_EN is defined).
// Covers latency, div0, restart rejection, mid-op reset and HI/LO hold behaviour.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div0;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operands as the build interprets them.
  function automatic void model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                output logic z, output logic [31:0] eh, output logic [31:0] el);
    longint sx, sy, p, q, r;
`ifdef MULDIV_SIGNED_EN
    sx = longint'($signed(x));
    sy = longint'($signed(y));
`else
    sx = longint'({32'd0, x});
    sy = longint'({32'd0, y});
`endif
    z  = 1'b0;
    eh = 32'd0;
    el = 32'd0;
    if (o == 1'b0) begin
      p  = sx * sy;
      eh = p[63:32];
      el = p[31:0];
    end else if (y == 32'd0) begin
      z = 1'b1;
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      el = q[31:0];
      eh = r[31:0];
    end
  endfunction

  task automatic run_op(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y,
                        input bit repulse, input bit start_on_done);
    logic        z;
    logic [31:0] eh, el;
    int          cyc;
    bit          hold_ok, seen;
    model(o, x, y, z, eh, el);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom);
    chk({tag, ".busy"}, busy, 1);
    cyc = 0; hold_ok = 1; seen = 0;
    while (cyc < 60 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (done || div0) seen = 1;
      else begin
        if (hi !== last_hi || lo !== last_lo || hi_we || lo_we) hold_ok = 0;
        if (repulse && (cyc == 4 || cyc == 19)) begin
          start = 1'b1; op = 1'($urandom); a = $urandom; b = $urandom;
        end
      end
    end
    if (!seen) begin
      chk({tag, ".timeout"}, 0, 1);
      return;
    end
    chk({tag, ".hold"}, hold_ok, 1);
    if (z) begin
      chk({tag, ".div0_lat"}, cyc, 1);
      chk({tag, ".div0"}, div0, 1);
      chk({tag, ".no_done"}, {done, hi_we, lo_we}, 0);
      chk({tag, ".hi_kept"}, hi, last_hi);
      chk({tag, ".lo_kept"}, lo, last_lo);
    end else begin
      chk({tag, ".latency"}, cyc, 35);
      chk({tag, ".we"}, {hi_we, lo_we}, 2'b11);
      chk({tag, ".hi"}, hi, eh);
      chk({tag, ".lo"}, lo, el);
      last_hi = eh;
      last_lo = el;
      if (start_on_done) begin
        start = 1'b1; op = 1'b0; a = 32'd1; b = 32'd1;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".pulse_end"}, {done, div0, hi_we, lo_we}, 0);
    if (start_on_done) chk({tag, ".restart_ignored"}, busy, 0);
  endtask

  initial begin
    bit seen;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.pulses", {done, div0, hi_we, lo_we}, 0);
    chk("rst.hi", hi, 0);
    chk("rst.lo", lo, 0);
    reset = 1'b0;

    run_op("mul7x6", 1'b0, 32'd7, 32'd6, 0, 1);
    run_op("div100_7", 1'b1, 32'd100, 32'd7, 0, 0);
    run_op("div5_0", 1'b1, 32'd5, 32'd0, 0, 0);
`ifdef MULDIV_SIGNED_EN
    run_op("div-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
`endif
    run_op("mul_ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("mul_repulse", 1'b0, 32'h0001_2345, 32'h0000_0ABC, 1, 0);

    // Reset during RUN must abort without a result and clear HI/LO.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd12345; b = 32'd678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst.busy", busy, 0);
    chk("midrst.hi", hi, 0);
    chk("midrst.lo", lo, 0);
    last_hi = 32'd0;
    last_lo = 32'd0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || hi_we || lo_we) seen = 1;
    end
    chk("midrst.no_done", seen, 0);
    run_op("mul3x3", 1'b0, 32'd3, 32'd3, 0, 0);

    for (int i = 0; i < 40; i++) begin
      logic        ro;
      logic [31:0] rx, ry;
      ro = 1'($urandom);
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: ry = 32'($urandom_range(1, 15));
        2: rx = 32'h8000_0000;
        3: ry = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), ro, rx, ry, (i % 5) == 0, (i % 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
